conv2d_mac: RTL and testbench

Pipelined multiply-accumulate stage for the 2-D convolution datapath. Sits directly downstream of `window_buffer`. Each cycle it takes one K×K pixel window and a held K×K signed weight set, and produces one rounded, saturated output pixel. It also owns weight loading through a small state machine and propagates the frame-end marker with matching latency.

---
 rtl/conv2d_pkg.sv | 28 ++
 rtl/conv2d_mac_if.sv | 40 ++++
 rtl/conv2d_mac_adder_tree.sv | 85 ++++++++
 rtl/conv2d_mac.sv | 154 +++++++++++++++
 tb/tb_conv2d_mac.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared types and sizing helpers for the conv2d MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv2d_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mac_state_t;

    // Width that holds K*K products of a zero-extended pixel and a signed weight
    function automatic int sum_width(input int bwd, input int wwd, input int k);
        return bwd + wwd + 1 + $clog2(k * k);
    endfunction

    // Product stage + adder-tree levels + round/saturate stage
    function automatic int mac_latency(input int k);
        return $clog2(k * k) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_mac_if.sv
// ============================================================================
// Module      : conv2d_mac_if
// Description : Weight-load, window-in and pixel-out signals of conv2d_mac.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv2d_mac_if #(
    parameter int K_KERNEL = 3,
    parameter int BWD      = 8,
    parameter int WWD      = 8,
    parameter int OWD      = 8
);
    logic signed [WWD-1:0]                        i_weight;
    logic                                         i_weight_valid;
    logic                                         o_weight_ready;
    logic                                         i_reload;
    logic [K_KERNEL-1:0][K_KERNEL-1:0][BWD-1:0]   i_window;
    logic                                         i_window_valid;
    logic                                         i_window_end;
    logic [OWD-1:0]                               o_pixel;
    logic                                         o_pixel_valid;
    logic                                         o_frame_end;
    logic                                         o_drop;

    modport slave (
        input  i_weight, i_weight_valid, i_reload,
        input  i_window, i_window_valid, i_window_end,
        output o_weight_ready, o_pixel, o_pixel_valid, o_frame_end, o_drop
    );

    modport master (
        output i_weight, i_weight_valid, i_reload,
        output i_window, i_window_valid, i_window_end,
        input  o_weight_ready, o_pixel, o_pixel_valid, o_frame_end, o_drop
    );

endinterface

`default_nettype wire

// File: rtl/conv2d_mac_adder_tree.sv
// ============================================================================
// Module      : adder_tree
// Description : Registered pipelined binary adder tree with valid/end tags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree #(
    parameter int N_LEAF = 9,
    parameter int WIDTH  = 21
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] i_leaf [N_LEAF],
    input  logic                    i_valid,
    input  logic                    i_end,
    output logic signed [WIDTH-1:0] o_sum,
    output logic                    o_valid,
    output logic                    o_end,
    output logic                    o_busy
);

    localparam int c_levels = $clog2(N_LEAF);

    function automatic int node_cnt(input int lvl);
        return (N_LEAF + (1 << lvl) - 1) >> lvl;
    endfunction

    // Nodes of all levels >= 1 live in one flat array; this is a level's base index
    function automatic int node_off(input int lvl);
        int s;
        s = 0;
        for (int m = 1; m < lvl; m++) s += node_cnt(m);
        return s;
    endfunction

    localparam int c_nodes = node_off(c_levels + 1);

    logic signed [WIDTH-1:0] r_node [c_nodes];
    logic [c_levels:1]       r_vld;
    logic [c_levels:1]       r_end;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_vld <= '0;
            r_end <= '0;
        end else begin
            r_vld[1] <= i_valid;
            r_end[1] <= i_end;
            for (int l = 2; l <= c_levels; l++) begin
                r_vld[l] <= r_vld[l-1];
                r_end[l] <= r_end[l-1];
            end
        end
    end

    // An odd node at the end of a level is passed up unchanged
    for (genvar l = 1; l <= c_levels; l++) begin : g_level
        for (genvar k = 0; k < node_cnt(l); k++) begin : g_node
            localparam int c_dst = node_off(l) + k;
            localparam int c_src = node_off(l - 1) + 2 * k;
            if (l == 1) begin : g_from_leaf
                if (2 * k + 1 < N_LEAF) begin : g_pair
                    always_ff @(posedge clk) r_node[c_dst] <= i_leaf[2*k] + i_leaf[2*k+1];
                end else begin : g_pass
                    always_ff @(posedge clk) r_node[c_dst] <= i_leaf[2*k];
                end
            end else begin : g_from_node
                if (2 * k + 1 < node_cnt(l - 1)) begin : g_pair
                    always_ff @(posedge clk) r_node[c_dst] <= r_node[c_src] + r_node[c_src+1];
                end else begin : g_pass
                    always_ff @(posedge clk) r_node[c_dst] <= r_node[c_src];
                end
            end
        end
    end

    assign o_sum   = r_node[c_nodes-1];
    assign o_valid = r_vld[c_levels];
    assign o_end   = r_end[c_levels];
    assign o_busy  = |r_vld;

endmodule

`default_nettype wire

// File: rtl/conv2d_mac.sv
// ============================================================================
// Module      : conv2d_mac
// Description : Pipelined KxK multiply-accumulate with weight-load FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_mac
    import conv2d_pkg::*;
#(
    parameter int K_KERNEL = 3,
    parameter int BWD      = 8,
    parameter int WWD      = 8,
    parameter int OWD      = 8,
    parameter int SHIFT    = 4
) (
    input  logic         clk,
    input  logic         clear,
    conv2d_mac_if.slave  bus
);

    localparam int c_taps   = K_KERNEL * K_KERNEL;
    localparam int c_cnt_w  = $clog2(c_taps);
    localparam int c_prod_w = BWD + WWD + 1;
    localparam int c_sum_w  = sum_width(BWD, WWD, K_KERNEL);

    // One spare bit so adding the rounding constant can never wrap
    localparam logic signed [c_sum_w:0] c_round    = (c_sum_w+1)'((64'(1) << SHIFT) >> 1);
    localparam logic signed [c_sum_w:0] c_pix_max  = (c_sum_w+1)'((64'(1) << OWD) - 1);

    mac_state_t                 r_state;
    mac_state_t                 w_state_next;
    logic signed [WWD-1:0]      r_weight [c_taps];
    logic [c_cnt_w-1:0]         r_load_cnt;
    logic                       w_accept;
    logic                       w_load_wr;
    logic                       w_load_last;
    logic                       w_pipe_busy;

    logic signed [c_prod_w-1:0] r_prod [c_taps];
    logic signed [c_sum_w-1:0]  w_leaf [c_taps];
    logic                       r_prod_valid;
    logic                       r_prod_end;

    logic signed [c_sum_w-1:0]  w_tree_sum;
    logic                       w_tree_valid;
    logic                       w_tree_end;
    logic                       w_tree_busy;

    logic signed [c_sum_w:0]    w_rounded;
    logic signed [c_sum_w:0]    w_shifted;
    logic [OWD-1:0]             w_pixel_sat;

    logic [OWD-1:0]             r_pixel;
    logic                       r_pixel_valid;
    logic                       r_frame_end;
    logic                       r_drop;

    assign w_accept    = bus.i_window_valid && (r_state == RUN);
    assign w_load_wr   = bus.i_weight_valid && (r_state == LOAD);
    assign w_load_last = w_load_wr && (r_load_cnt == c_cnt_w'(c_taps - 1));
    // The output register is not counted: the result can leave while the FSM returns to LOAD
    assign w_pipe_busy = r_prod_valid || w_tree_busy;

    always_ff @(posedge clk) begin
        if (clear) r_state <= LOAD;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    if (w_load_last)   w_state_next = RUN;
            RUN:     if (bus.i_reload)  w_state_next = DRAIN;
            DRAIN:   if (!w_pipe_busy)  w_state_next = LOAD;
            default:                    w_state_next = LOAD;
        endcase
    end

    assign bus.o_weight_ready = (r_state == LOAD);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_load_cnt <= '0;
            for (int n = 0; n < c_taps; n++) r_weight[n] <= '0;
        end else if (w_load_wr) begin
            r_weight[r_load_cnt] <= bus.i_weight;
            r_load_cnt           <= w_load_last ? '0 : r_load_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < c_taps; k++) begin : g_tap
        always_ff @(posedge clk) begin
            r_prod[k] <= c_prod_w'($signed({1'b0, bus.i_window[k / K_KERNEL][k % K_KERNEL]}))
                       * c_prod_w'(r_weight[k]);
        end
        assign w_leaf[k] = c_sum_w'(r_prod[k]);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_prod_valid <= 1'b0;
            r_prod_end   <= 1'b0;
        end else begin
            r_prod_valid <= w_accept;
            r_prod_end   <= w_accept && bus.i_window_end;
        end
    end

    adder_tree #(
        .N_LEAF (c_taps),
        .WIDTH  (c_sum_w)
    ) u_adder_tree (
        .clk     (clk),
        .clear   (clear),
        .i_leaf  (w_leaf),
        .i_valid (r_prod_valid),
        .i_end   (r_prod_end),
        .o_sum   (w_tree_sum),
        .o_valid (w_tree_valid),
        .o_end   (w_tree_end),
        .o_busy  (w_tree_busy)
    );

    always_comb begin
        w_rounded = (c_sum_w+1)'(w_tree_sum) + c_round;
        w_shifted = w_rounded >>> SHIFT;
        if (w_shifted < 0)              w_pixel_sat = '0;
        else if (w_shifted > c_pix_max) w_pixel_sat = '1;
        else                            w_pixel_sat = w_shifted[OWD-1:0];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_end   <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_pixel_valid <= w_tree_valid;
            r_frame_end   <= w_tree_valid && w_tree_end;
            if (w_tree_valid) r_pixel <= w_pixel_sat;
            if (bus.i_window_valid && (r_state != RUN)) r_drop <= 1'b1;
        end
    end

    assign bus.o_pixel       = r_pixel;
    assign bus.o_pixel_valid = r_pixel_valid;
    assign bus.o_frame_end   = r_frame_end;
    assign bus.o_drop        = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_conv2d_mac.sv
// ============================================================================
// Module      : tb_conv2d_mac
// Description : Randomized bench for conv2d_mac (SHIFT=0 and SHIFT=4 copies).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2d_mac;

    localparam int K      = 3;
    localparam int NT     = K * K;
    localparam int L      = 6;
    localparam int MAXC   = 2048;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_DRAIN = 2;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    conv2d_mac_if #(.K_KERNEL(K), .BWD(8), .WWD(8), .OWD(8)) bus0 ();
    conv2d_mac_if #(.K_KERNEL(K), .BWD(8), .WWD(8), .OWD(8)) bus4 ();

    conv2d_mac #(.K_KERNEL(K), .BWD(8), .WWD(8), .OWD(8), .SHIFT(0)) dut0 (
        .clk (clk), .clear (clear), .bus (bus0.slave));
    conv2d_mac #(.K_KERNEL(K), .BWD(8), .WWD(8), .OWD(8), .SHIFT(4)) dut4 (
        .clk (clk), .clear (clear), .bus (bus4.slave));

    // Model state for the current cycle
    int cyc = 0;
    int m_state = M_LOAD;
    int m_w [NT];
    int m_cnt = 0;
    int m_last_acc = -100;
    bit m_drop = 1'b0;
    int cur_px [NT];

    // Expected outputs indexed by cycle
    bit exp_v   [MAXC];
    bit exp_e   [MAXC];
    bit exp_clr [MAXC];
    int exp_p0  [MAXC];
    int exp_p4  [MAXC];
    bit lit_en  [MAXC];
    int lit0    [MAXC];
    int lit4    [MAXC];
    bit rdy_en  [MAXC];
    bit rdy_val [MAXC];

    int n_vec = 0;
    int n_err = 0;

    function automatic int round_sat(input int s, input int sh);
        int r;
        r = s;
        if (sh > 0) r = r + (1 << (sh - 1));
        r = r >>> sh;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, both DUT copies against the model
    int last0 = 0;
    int last4 = 0;
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (exp_clr[cyc]) begin last0 = 0; last4 = 0; end
            if (exp_v[cyc])   begin last0 = exp_p0[cyc]; last4 = exp_p4[cyc]; end
            chk("valid0", 32'(bus0.o_pixel_valid), 32'(exp_v[cyc]));
            chk("valid4", 32'(bus4.o_pixel_valid), 32'(exp_v[cyc]));
            chk("pixel0", 32'(bus0.o_pixel), last0);
            chk("pixel4", 32'(bus4.o_pixel), last4);
            chk("fend0",  32'(bus0.o_frame_end), 32'(exp_v[cyc] && exp_e[cyc]));
            chk("fend4",  32'(bus4.o_frame_end), 32'(exp_v[cyc] && exp_e[cyc]));
            chk("drop0",  32'(bus0.o_drop), 32'(m_drop));
            chk("drop4",  32'(bus4.o_drop), 32'(m_drop));
            chk("ready0", 32'(bus0.o_weight_ready), 32'(m_state == M_LOAD));
            chk("ready4", 32'(bus4.o_weight_ready), 32'(m_state == M_LOAD));
            if (lit_en[cyc]) begin
                chk("lit_pixel0", 32'(bus0.o_pixel), lit0[cyc]);
                chk("lit_pixel4", 32'(bus4.o_pixel), lit4[cyc]);
                chk("lit_valid0", 32'(bus0.o_pixel_valid), 32'd1);
            end
            if (rdy_en[cyc]) chk("lit_ready", 32'(bus0.o_weight_ready), 32'(rdy_val[cyc]));
        end
    end

    // Drive one cycle of inputs, advance the model, wait for the clock edge
    task automatic tick(input bit wv, input int w, input bit winv, input bit wend,
                        input bit rel, input bit clr);
        int nxt;
        bit nd;
        int s;
        nxt = m_state;
        nd  = m_drop;
        clear = clr;
        bus0.i_weight = 8'(w);      bus4.i_weight = 8'(w);
        bus0.i_weight_valid = wv;   bus4.i_weight_valid = wv;
        bus0.i_reload = rel;        bus4.i_reload = rel;
        bus0.i_window_valid = winv; bus4.i_window_valid = winv;
        bus0.i_window_end = wend;   bus4.i_window_end = wend;
        for (int n = 0; n < NT; n++) begin
            bus0.i_window[n / K][n % K] = 8'(cur_px[n]);
            bus4.i_window[n / K][n % K] = 8'(cur_px[n]);
        end
        if (clr) begin
            nxt = M_LOAD;
            nd  = 1'b0;
            m_cnt = 0;
            m_last_acc = -100;
            for (int n = 0; n < NT; n++) m_w[n] = 0;
            for (int k = 1; k < L; k++) begin exp_v[cyc+k] = 1'b0; exp_e[cyc+k] = 1'b0; end
            exp_clr[cyc+1] = 1'b1;
        end else begin
            if (winv && m_state != M_RUN) nd = 1'b1;
            if (m_state == M_LOAD) begin
                if (wv) begin
                    m_w[m_cnt] = w;
                    if (m_cnt == NT - 1) begin m_cnt = 0; nxt = M_RUN; end
                    else m_cnt++;
                end
            end else if (m_state == M_RUN) begin
                if (winv) begin
                    s = 0;
                    for (int n = 0; n < NT; n++) s += cur_px[n] * m_w[n];
                    exp_v[cyc+L]  = 1'b1;
                    exp_e[cyc+L]  = wend;
                    exp_p0[cyc+L] = round_sat(s, 0);
                    exp_p4[cyc+L] = round_sat(s, 4);
                    m_last_acc = cyc;
                end
                if (rel) nxt = M_DRAIN;
            end else begin
                // Drained once the newest accepted window has had L cycles to leave
                if (cyc - m_last_acc >= L) nxt = M_LOAD;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_state = nxt;
        m_drop  = nd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_px(input int v);
        for (int n = 0; n < NT; n++) cur_px[n] = v;
    endtask

    task automatic pin(input int p0, input int p4);
        lit_en[cyc+L] = 1'b1;
        lit0[cyc+L]   = p0;
        lit4[cyc+L]   = p4;
    endtask

    task automatic load_const(input int w);
        for (int n = 0; n < NT; n++) tick(1, w, 0, 0, 0, 0);
    endtask

    initial begin
        int w;
        for (int n = 0; n < NT; n++) begin m_w[n] = 0; cur_px[n] = 0; end
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        idle(2);

        // Window before any weight load is dropped
        set_px(9);
        tick(0, 0, 1, 0, 0, 0);
        idle(1);
        tick(0, 0, 0, 0, 0, 1);
        idle(1);

        // Unit weights, pixel 10: 90 raw, (90+8)>>4 = 6
        load_const(1);
        set_px(10);
        pin(90, 6);
        tick(0, 0, 1, 0, 0, 0);
        idle(7);

        // Reload together with a window; ready rises 7 cycles later
        pin(90, 6);
        rdy_en[cyc+6] = 1'b1; rdy_val[cyc+6] = 1'b0;
        rdy_en[cyc+7] = 1'b1; rdy_val[cyc+7] = 1'b1;
        tick(0, 0, 1, 0, 1, 0);
        idle(2);
        tick(0, 0, 1, 0, 0, 0);
        idle(6);

        // Identity kernel
        tick(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < NT; n++) tick(1, (n == 4) ? 16 : 0, 0, 0, 0, 0);
        for (int n = 0; n < NT; n++) cur_px[n] = int'($urandom_range(0, 255));
        cur_px[4] = 200;
        pin(255, 200);
        tick(0, 0, 1, 0, 0, 0);
        cur_px[4] = 7;
        pin(112, 7);
        tick(0, 0, 1, 0, 0, 0);
        idle(7);
        tick(0, 0, 0, 0, 1, 0);
        idle(8);

        // Clamp low and high
        load_const(-1);
        set_px(50);
        pin(0, 0);
        tick(0, 0, 1, 0, 0, 0);
        idle(7);
        tick(0, 0, 0, 0, 1, 0);
        idle(8);
        load_const(127);
        set_px(255);
        pin(255, 255);
        tick(0, 0, 1, 0, 0, 0);
        idle(7);

        // 36-window frame, back to back
        for (int i = 0; i < 36; i++) begin
            for (int n = 0; n < NT; n++) cur_px[n] = int'($urandom_range(0, 255));
            tick(0, 0, 1, (i == 35), 0, 0);
        end
        idle(7);

        // Clear three cycles after a window, then a window before any load
        tick(0, 0, 1, 0, 0, 0);
        idle(2);
        tick(0, 0, 0, 0, 0, 1);
        idle(8);
        tick(0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < NT; n++) cur_px[n] = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) w = int'($urandom_range(0, 255)) - 128;
            else                           w = int'($urandom_range(0, 6)) - 2;
            tick(($urandom_range(0, 1) == 1), w, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
